// File: rtl/conv_window_shift_pkg.sv
// Shared types and default geometry for the convolution sliding-window buffer.
package conv_window_shift_pkg;

    localparam int WIDTH_DEF  = 16;
    localparam int LEN_DEF    = 8;
    localparam int STRIDE_DEF = 1;
    localparam int IDXW_DEF   = 16;

    typedef logic [WIDTH_DEF-1:0] data_t;
    typedef data_t [LEN_DEF-1:0]  data_vector_t;

    typedef enum logic [1:0] {
        EMIT_NONE   = 2'd0,
        EMIT_FILL   = 2'd1,
        EMIT_STRIDE = 2'd2
    } emit_kind_e;

endpackage

// File: rtl/conv_window_shift_if.sv
// Sample-in / window-out handshake bundle for conv_window_shift.
interface conv_window_shift_if #(
    parameter int WIDTH = conv_window_shift_pkg::WIDTH_DEF,
    parameter int LEN   = conv_window_shift_pkg::LEN_DEF,
    parameter int IDXW  = conv_window_shift_pkg::IDXW_DEF
);

    logic                      clr;
    logic [WIDTH-1:0]          in_data;
    logic                      in_valid;
    logic                      in_ready;
    logic [LEN-1:0][WIDTH-1:0] out_data;
    logic                      out_valid;
    logic                      out_ready;
    logic [IDXW-1:0]           out_idx;

    modport master (
        output clr, in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, out_idx
    );

    modport slave (
        input  clr, in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, out_idx
    );

endinterface

// File: rtl/conv_emit_ctrl.sv
// Fill and stride bookkeeping: decides which accepted samples complete a window to emit.
module conv_emit_ctrl
    import conv_window_shift_pkg::*;
#(
    parameter int LEN    = LEN_DEF,
    parameter int STRIDE = STRIDE_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic accept,
    output logic emit
);

    localparam int            CW         = $clog2(LEN + 1);
    localparam logic [CW-1:0] FILL_LAST  = CW'(LEN - 1);
    localparam logic [CW-1:0] FILL_FULL  = CW'(LEN);
    localparam logic [CW-1:0] STRIDE_END = CW'(STRIDE);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO   = CW'(0);

    logic [CW-1:0] fill_cnt_r;
    logic [CW-1:0] stride_cnt_r;
    logic [CW-1:0] stride_inc_s;
    logic [CW-1:0] stride_next_s;
    emit_kind_e    kind_s;

    // Classify the incoming accept and work out the stride counter's next value
    always_comb begin
        kind_s        = EMIT_NONE;
        stride_inc_s  = stride_cnt_r + CNT_ONE;
        stride_next_s = stride_cnt_r;
        if (!accept) begin
            kind_s = EMIT_NONE;
        end else if (fill_cnt_r == FILL_LAST) begin
            kind_s        = EMIT_FILL;
            stride_next_s = CNT_ZERO;
        end else if (fill_cnt_r == FILL_FULL) begin
            if (stride_inc_s == STRIDE_END) begin
                kind_s        = EMIT_STRIDE;
                stride_next_s = CNT_ZERO;
            end else begin
                kind_s        = EMIT_NONE;
                stride_next_s = stride_inc_s;
            end
        end else begin
            kind_s = EMIT_NONE;
        end
    end

    assign emit = (kind_s != EMIT_NONE);

    // Fill counter saturates at LEN; stride counter only moves once the window is full
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill_cnt_r   <= CNT_ZERO;
            stride_cnt_r <= CNT_ZERO;
        end else if (clr) begin
            fill_cnt_r   <= CNT_ZERO;
            stride_cnt_r <= CNT_ZERO;
        end else if (accept) begin
            if (fill_cnt_r != FILL_FULL) begin
                fill_cnt_r <= fill_cnt_r + CNT_ONE;
            end else begin
                fill_cnt_r <= fill_cnt_r;
            end
            stride_cnt_r <= stride_next_s;
        end else begin
            fill_cnt_r   <= fill_cnt_r;
            stride_cnt_r <= stride_cnt_r;
        end
    end

endmodule

// File: rtl/conv_window_shift.sv
// LEN-deep sliding window over a sample stream; presents the full window every STRIDE accepts.
module conv_window_shift
    import conv_window_shift_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int LEN    = LEN_DEF,
    parameter int STRIDE = STRIDE_DEF,
    parameter int IDXW   = IDXW_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    conv_window_shift_if.slave bus
);

    typedef logic [WIDTH-1:0]     win_data_t;
    typedef win_data_t [LEN-1:0]  win_vector_t;

    localparam logic [IDXW-1:0] IDX_ONE  = IDXW'(1);
    localparam logic [IDXW-1:0] IDX_ZERO = IDXW'(0);

    win_vector_t     window_r;
    logic            out_valid_r;
    logic [IDXW-1:0] out_idx_r;
    logic            in_ready_s;
    logic            accept_s;
    logic            xfer_s;
    logic            emit_s;

    // Ready depends only on state and clr, never on in_valid
    assign in_ready_s = rst_n && !bus.clr && (!out_valid_r || bus.out_ready);
    assign accept_s   = bus.in_valid && in_ready_s;
    assign xfer_s     = out_valid_r && bus.out_ready && !bus.clr;

    conv_emit_ctrl #(
        .LEN    (LEN),
        .STRIDE (STRIDE)
    ) u_emit_ctrl (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (bus.clr),
        .accept (accept_s),
        .emit   (emit_s)
    );

    // Shift array, presented-window flag and window index
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            window_r    <= win_vector_t'(0);
            out_valid_r <= 1'b0;
            out_idx_r   <= IDX_ZERO;
        end else if (bus.clr) begin
            window_r    <= win_vector_t'(0);
            out_valid_r <= 1'b0;
            out_idx_r   <= IDX_ZERO;
        end else begin
            if (accept_s) begin
                window_r <= {bus.in_data, window_r[LEN-1:1]};
            end else begin
                window_r <= window_r;
            end

            if (xfer_s) begin
                out_idx_r <= out_idx_r + IDX_ONE;
            end else begin
                out_idx_r <= out_idx_r;
            end

            // A new emitting accept on the transfer edge keeps the output valid with no bubble
            if (accept_s && emit_s) begin
                out_valid_r <= 1'b1;
            end else if (xfer_s) begin
                out_valid_r <= 1'b0;
            end else begin
                out_valid_r <= out_valid_r;
            end
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_data  = window_r;
    assign bus.out_valid = out_valid_r;
    assign bus.out_idx   = out_idx_r;

endmodule
